imem_boot_loader: RTL and testbench

- Writer side of the instruction memory. The single-cycle datapath only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words.
- Writes each word into instruction memory, then releases the core via core_run.
- Holds the datapath idle (core_run=0) from reset until a load completes with a good checksum.

---
 rtl/imem_boot_loader.sv | 154 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream loader that fills instruction memory and releases the core
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_run,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // Largest legal word count is the full memory depth; anything above is rejected.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [23:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        in_load;
  logic        xfer;
  logic [15:0] len_new;

  // The stream is only accepted in the four loading states; ready is a pure
  // decode of the registered state so it never depends on byte_valid.
  assign in_load = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer    = byte_valid && in_load;
  assign len_new = {len_q[15:8], byte_in};

  assign byte_ready = in_load;
  assign busy       = in_load;
  assign done       = (state_q == S_DONE);
  assign core_run   = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  // State and datapath registers, all cleared by reset in any state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic: parse length, assemble big-endian words, verify checksum.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {byte_in, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if ({1'b0, len_new} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_new == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d     = csum_q ^ byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], byte_in};
          if (byte_cnt_q == 2'd3) begin
            // Word complete: the write strobe appears in the following cycle.
            we_d       = 1'b1;
            wdata_d    = {shift_q, byte_in};
            addr_d     = {14'd0, word_cnt_q, 2'b00};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == len_q - 16'd1) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];
  logic [7:0]  stream[$];
  logic        exp_done;
  logic        exp_err;
  logic [7:0]  model_csum;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: derive the expected writes and final outcome straight from the stream format.
  task automatic model_build();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    x = 8'h00;
    n = {stream[0], stream[1]};
    if (n > (1 << AW)) begin
      exp_done   = 1'b0;
      exp_err    = 1'b1;
      model_csum = 8'h00;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
      for (int j = 0; j < 4; j++) x = x ^ stream[2+4*i+j];
    end
    model_csum = x;
    exp_done   = (stream[2+4*n] == x);
    exp_err    = !exp_done;
  endtask

  // Per-cycle compare: every write must match the model, in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_we === 1'b1) begin
        seen_addr.push_back(imem_addr);
        seen_data.push_back(imem_wdata);
        if (exp_addr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
        end else begin
          check("wr_addr", imem_addr, exp_addr.pop_front());
          check("wr_data", imem_wdata, exp_data.pop_front());
        end
      end
      check("ready_vs_busy", 32'(byte_ready), 32'(busy));
      check("run_vs_done", 32'(core_run), 32'(done));
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int budget;
    budget = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got byte_ready 0, expected 1");
    end else begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input bit gaps, input int start_at, input int stop_after);
    pulse_start();
    for (int i = 0; i < stream.size(); i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      if (gaps) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      if (i == start_at) start = 1'b1;
      send(stream[i]);
      start = 1'b0;
    end
  endtask

  task automatic finish_check();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("core_run", 32'(core_run), 32'(exp_done));
    check("busy_end", 32'(busy), 32'd0);
    check("writes_pending", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, byte_ready, imem_we, core_run, busy, done, err}, 32'd0);
    check({name, "_addr"}, imem_addr, 32'd0);
    check({name, "_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    check_all_zero("reset_state");

    // Basic load
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
    model_build();
    check("model_csum", 32'(model_csum), 32'h89);
    check("model_w1", exp_data[1], 32'hAC080000);
    seen_addr.delete();
    seen_data.delete();
    run(1'b0, -1, -1);
    finish_check();
    check("basic_nwrites", 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() == 2) begin
      check("basic_a0", seen_addr[0], 32'h0);
      check("basic_d0", seen_data[0], 32'h20080005);
      check("basic_a1", seen_addr[1], 32'h4);
      check("basic_d1", seen_data[1], 32'hAC080000);
    end
    check("basic_done_lit", {30'd0, done, err}, 32'b10);

    // Bad checksum
    stream[10] = 8'h88;
    model_build();
    run(1'b0, -1, -1);
    finish_check();
    check("bad_err_lit", {29'd0, done, err, core_run}, 32'b010);
    pulse_start();
    check("restart_err", 32'(err), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    do_reset();

    // Empty load
    stream = '{8'h00, 8'h00, 8'h00};
    model_build();
    seen_addr.delete();
    run(1'b0, -1, -1);
    finish_check();
    check("empty_nwrites", 32'(seen_addr.size()), 32'd0);
    check("empty_done_lit", 32'(done), 32'd1);

    // Oversize count
    stream = '{8'h04, 8'h01};
    model_build();
    run(1'b0, -1, -1);
    check("oversize_err_lit", 32'(err), 32'd1);
    check("oversize_ready", 32'(byte_ready), 32'd0);
    finish_check();

    // Exactly full memory is accepted: only the length prefix is checked here
    stream = '{8'h04, 8'h00};
    run(1'b0, -1, -1);
    check("full_len_busy", 32'(busy), 32'd1);
    check("full_len_err", 32'(err), 32'd0);
    do_reset();

    // Backpressure
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
    model_build();
    seen_addr.delete();
    run(1'b1, -1, -1);
    finish_check();
    check("bp_nwrites", 32'(seen_addr.size()), 32'd2);

    // Reset mid-load after 6 payload bytes
    model_build();
    void'(exp_addr.pop_back());
    void'(exp_data.pop_back());
    run(1'b0, -1, 8);
    check("midload_wr_seen", 32'(exp_addr.size()), 32'd0);
    do_reset();
    check_all_zero("midload_reset");
    model_build();
    seen_addr.delete();
    seen_data.delete();
    run(1'b0, -1, -1);
    finish_check();
    if (seen_addr.size() > 0) check("reload_a0", seen_addr[0], 32'h0);

    // start while busy in DATA
    model_build();
    run(1'b0, 4, -1);
    finish_check();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
